// File: rtl/seq_count_var_dn.sv
// seq_count_var_dn: loadable binary down-counter used as a variable-length
// delay/timeout in sequential control paths.
//
// A load takes in_ at the next rising edge, and the count then steps down by
// one per cycle until it reaches zero. done flags the zero state and is
// decoded from the count register only.
//
// Optional build macro SEQ_COUNT_VAR_DN_WRAP_EN:
//   undefined (default): the count holds at zero until the next load.
//   defined:             the count wraps from zero to all-ones and free-runs.
module seq_count_var_dn #(
   parameter int nbits = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic [nbits-1:0] in_,
   output logic [nbits-1:0] out,
   output logic             done
);

   logic [nbits-1:0] count_q;
   logic [nbits-1:0] count_d;

   // Next count: a load overrides everything, otherwise decrement while non-zero.
   always_comb begin
      count_d = count_q;
      if (ld) begin
         count_d = in_;
      end else if (count_q != '0) begin
         count_d = count_q - nbits'(1);
      end else begin
`ifdef SEQ_COUNT_VAR_DN_WRAP_EN
         count_d = '1;
`else
         count_d = '0;
`endif
      end
   end

   // Count register; reset has priority over a load in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Outputs come straight from the register, so ld/in_ never reach them combinationally.
   assign out  = count_q;
   assign done = (count_q == '0);

endmodule

// File: tb/tb_seq_count_var_dn.sv
// Testbench for seq_count_var_dn (nbits = 3).
// Expected values are pushed to a scoreboard queue when each input set is
// driven, and compared after the following rising edge.
module tb_seq_count_var_dn;

   logic       clk = 1'b0;
   logic       reset;
   logic       ld;
   logic [2:0] in_;
   logic [2:0] out;
   logic       done;

   seq_count_var_dn #(.nbits(3)) dut (
      .clk  (clk),
      .reset(reset),
      .ld   (ld),
      .in_  (in_),
      .out  (out),
      .done (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] out;
      logic       done;
      string      name;
   } exp_t;

   typedef struct {
      logic       reset;
      logic       ld;
      logic [2:0] in_;
      logic [2:0] exp_out;
      logic       exp_done;
   } vec_t;

   exp_t       sb[$];
   vec_t       vecs[$];
   int         checks = 0;
   int         errors = 0;
   int         txn    = 0;
   logic [2:0] model  = 3'd0;

   function automatic vec_t mk(input logic r, input logic l, input logic [2:0] v,
                               input logic [2:0] eo, input logic ed);
      vec_t t;
      t.reset = r; t.ld = l; t.in_ = v; t.exp_out = eo; t.exp_done = ed;
      return t;
   endfunction

   // Golden next-state, written from the counter's behaviour description.
   function automatic logic [2:0] next_model(input logic [2:0] c, input logic r,
                                             input logic l, input logic [2:0] v);
      if (r)            return 3'd0;
      else if (l)       return v;
      else if (c != 0)  return c - 3'd1;
`ifdef SEQ_COUNT_VAR_DN_WRAP_EN
      else              return 3'd7;
`else
      else              return 3'd0;
`endif
   endfunction

   task automatic check_one();
      exp_t e;
      txn++;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL txn %0d scoreboard empty out=%0d done=%0b", txn, out, done);
      end else begin
         e = sb.pop_front();
         if (out !== e.out || done !== e.done) begin
            errors++;
            $display("FAIL txn %0d %s out=%0d done=%0b required out=%0d done=%0b",
                     txn, e.name, out, done, e.out, e.done);
         end else begin
            $display("txn %0d %s out=%0d done=%0b ok", txn, e.name, out, done);
         end
      end
   endtask

   // Drive one cycle with an explicitly stated expectation.
   task automatic drive_exp(input logic r, input logic l, input logic [2:0] v,
                            input logic [2:0] eo, input logic ed, input string nm);
      exp_t e;
      @(negedge clk);
      reset = r; ld = l; in_ = v;
      model = next_model(model, r, l, v);
      e.out = eo; e.done = ed; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_one();
   endtask

   // Drive one cycle with the expectation taken from the golden model.
   task automatic drive_model(input logic r, input logic l, input logic [2:0] v,
                              input string nm);
      exp_t e;
      @(negedge clk);
      reset = r; ld = l; in_ = v;
      model = next_model(model, r, l, v);
      e.out = model; e.done = (model == 3'd0); e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_one();
   endtask

   initial begin
      reset = 1'b1; ld = 1'b0; in_ = 3'd0;

      // Reset state, then load zero twice and idle.
      drive_exp(1, 0, 3'd0, 3'd0, 1'b1, "reset");
      drive_exp(0, 1, 3'd0, 3'd0, 1'b1, "load0");
      drive_exp(0, 1, 3'd0, 3'd0, 1'b1, "load0");
`ifndef SEQ_COUNT_VAR_DN_WRAP_EN
      for (int i = 0; i < 10; i++) drive_exp(0, 0, 3'd0, 3'd0, 1'b1, "idle0");

      // Table: load 4 then count, load 7 then count, both holding at zero.
      vecs.push_back(mk(1, 0, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(0, 1, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(0, 1, 3'd4, 3'd4, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd3, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd2, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd1, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1'b1));
      for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(1, 0, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(0, 1, 3'd7, 3'd7, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd6, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd5, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd4, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd3, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd2, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd1, 1'b0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1'b1));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1'b1));
      foreach (vecs[k])
         drive_exp(vecs[k].reset, vecs[k].ld, vecs[k].in_,
                   vecs[k].exp_out, vecs[k].exp_done, "table");

      // Load 5, run out and hold, then reload 3 from zero.
      drive_exp(0, 1, 3'd5, 3'd5, 1'b0, "load5");
      for (int i = 0; i < 10; i++)
         drive_exp(0, 0, 3'd0, (i < 4) ? 3'(4 - i) : 3'd0, (i >= 4), "cnt5");
      drive_exp(0, 1, 3'd3, 3'd3, 1'b0, "reload3");
      for (int i = 0; i < 10; i++)
         drive_exp(0, 0, 3'd0, (i < 2) ? 3'(2 - i) : 3'd0, (i >= 2), "cnt3");
`endif

      // Reload while non-zero: load 5, two decrements, load 6, continue.
      drive_exp(0, 1, 3'd5, 3'd5, 1'b0, "load5");
      drive_exp(0, 0, 3'd0, 3'd4, 1'b0, "dec");
      drive_exp(0, 0, 3'd0, 3'd3, 1'b0, "dec");
      drive_exp(0, 1, 3'd6, 3'd6, 1'b0, "reload6");
      drive_exp(0, 0, 3'd0, 3'd5, 1'b0, "dec");
      drive_exp(0, 0, 3'd0, 3'd4, 1'b0, "dec");

      // Reset wins over a simultaneous load.
      drive_exp(0, 1, 3'd7, 3'd7, 1'b0, "load7");
      drive_exp(0, 0, 3'd0, 3'd6, 1'b0, "dec");
      drive_exp(0, 0, 3'd0, 3'd5, 1'b0, "dec");
      drive_exp(1, 1, 3'd5, 3'd0, 1'b1, "rst_over_ld");

      // ld held high reloads every cycle; X on in_ with ld low is ignored.
      drive_exp(0, 1, 3'd2, 3'd2, 1'b0, "hold_ld");
      drive_exp(0, 1, 3'd5, 3'd5, 1'b0, "hold_ld");
      drive_exp(0, 1, 3'd3, 3'd3, 1'b0, "hold_ld");
      drive_exp(0, 0, 3'bxxx, 3'd2, 1'b0, "x_in");
      drive_exp(0, 0, 3'bxxx, 3'd1, 1'b0, "x_in");
      drive_exp(0, 0, 3'd0, 3'd0, 1'b1, "dec");

`ifdef SEQ_COUNT_VAR_DN_WRAP_EN
      // Zero wraps to 7 and keeps counting.
      drive_exp(0, 0, 3'd0, 3'd7, 1'b0, "wrap");
      drive_exp(0, 0, 3'd0, 3'd6, 1'b0, "wrap_dec");
`endif

      // Random ld/in_ against the golden model.
      for (int i = 0; i < 50; i++)
         drive_model(0, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), "rand");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover scoreboard entries=%0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout after %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule
